// File: rtl/count_pkg.sv
// Shared types and default sizes for the sequenced counter controller.
package count_pkg;

  localparam int WIDTH_DEF   = 24;
  localparam int PRESC_W_DEF = 8;

  // Controller states; encoding is fixed so debug probes decode consistently.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // True for the states in which the counter owns the datapath.
  function automatic logic state_is_busy(state_t s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/presc_div.sv
// Prescale divider: while enabled, produces one tick every div+1 cycles.
// The phase is frozen when disabled, so a paused run resumes mid-period.
module presc_div
  import count_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;

  assign tick = en && (presc_q == div);

  // Next phase: clear wins, wrap to zero on tick, otherwise advance while enabled.
  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a gated synchronous up-counter: takes a
// configuration (limit, prescale, reload mode) and runs the count under
// start/stop/clear commands, pulsing done at terminal count.
//
// Config handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high exactly when the controller is
// IDLE, so configuration is held off while a run is active or paused. The
// offering side keeps cfg_* stable while cfg_valid is high and unaccepted.
module count_seq_ctrl
  import count_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic [PRESC_W-1:0] cfg_div,
  input  logic               cfg_reload,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic [WIDTH-1:0]   count_out,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output state_t             dbg_state
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [PRESC_W-1:0] div_q, div_d;
  logic               reload_q, reload_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cfg_fire;
  logic               presc_en;
  logic               presc_clr;
  logic               presc_tick;
  logic               at_limit;

  assign cfg_fire = cfg_valid && (state_q == IDLE);
  assign presc_en = (state_q == RUN);
  // >= rather than == keeps the count from ever stepping past the limit.
  assign at_limit = (count_q >= limit_q);

  presc_div #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .div   (div_q),
    .tick  (presc_tick)
  );

  // Next-state, config latch and count update; clear > stop > start.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    div_d     = div_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;

    // A config accepted this cycle is the one a same-cycle start runs with.
    if (cfg_fire) begin
      limit_d  = cfg_limit;
      div_d    = cfg_div;
      reload_d = cfg_reload;
    end

    case (state_q)
      IDLE: begin
        if (clear) begin
          count_d   = '0;
          presc_clr = 1'b1;
        end else if (!stop && start && (limit_d != '0)) begin
          count_d   = '0;
          presc_clr = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (clear) begin
          count_d   = '0;
          presc_clr = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = stop ? PAUSE : RUN;
          if (presc_tick) begin
            if (at_limit) begin
              done_d = 1'b1;
              if (reload_q) begin
                count_d = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end
        end
      end

      PAUSE: begin
        if (clear) begin
          count_d   = '0;
          presc_clr = 1'b1;
          state_d   = IDLE;
        end else if (!stop && start) begin
          state_d = RUN;
        end
      end

      default: begin
        count_d   = '0;
        presc_clr = 1'b1;
        state_d   = IDLE;
      end
    endcase

    busy_d = state_is_busy(state_d);
  end

  // State, count, latched config and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      div_q    <= '0;
      reload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      div_q    <= div_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign count_out = count_q;
  assign tick      = presc_tick;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios plus a randomized run, all
// checked against an arithmetic model of elapsed run time.
module tb_count_seq_ctrl;

  localparam int WIDTH   = 24;
  localparam int PRESC_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               cfg_valid = 1'b0;
  logic [WIDTH-1:0]   cfg_limit = '0;
  logic [PRESC_W-1:0] cfg_div = '0;
  logic               cfg_reload = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               clear = 1'b0;
  logic               cfg_ready;
  logic [WIDTH-1:0]   count_out;
  logic               tick;
  logic               busy;
  logic               done;
  count_pkg::state_t  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  count_seq_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_limit  (cfg_limit),
    .cfg_div    (cfg_div),
    .cfg_reload (cfg_reload),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .count_out  (count_out),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 paused. m_n counts run cycles since start;
  // the count is the number of whole prescale periods, modulo limit+1.
  int m_mode = 0;
  int m_n = 0;
  int m_idle_count = 0;
  int m_limit = 0;
  int m_div = 0;
  bit m_reload = 1'b0;
  bit m_done = 1'b0;
  bit m_t, m_term;

  function automatic int exp_count();
    if (m_mode == 0) return m_idle_count;
    return (m_n / (m_div + 1)) % (m_limit + 1);
  endfunction

  function automatic bit exp_tick();
    return (m_mode == 1) && (((m_n + 1) % (m_div + 1)) == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_n = 0; m_idle_count = 0;
      m_limit = 0; m_div = 0; m_reload = 1'b0; m_done = 1'b0;
    end else begin
      m_t    = exp_tick();
      m_term = m_t && ((((m_n + 1) / (m_div + 1)) % (m_limit + 1)) == 0);
      m_done = 1'b0;
      case (m_mode)
        0: begin
          if (cfg_valid) begin
            m_limit = int'(cfg_limit); m_div = int'(cfg_div); m_reload = cfg_reload;
          end
          if (clear) m_idle_count = 0;
          else if (!stop && start && m_limit != 0) begin m_mode = 1; m_n = 0; end
        end
        1: begin
          if (clear) begin
            m_mode = 0; m_idle_count = 0;
          end else if (m_term) begin
            m_done = 1'b1;
            if (!m_reload) begin
              m_mode = 0; m_idle_count = m_limit;
            end else begin
              m_n++; m_mode = stop ? 2 : 1;
            end
          end else begin
            m_n++; m_mode = stop ? 2 : 1;
          end
        end
        default: begin
          if (clear) begin m_mode = 0; m_idle_count = 0; end
          else if (!stop && start) m_mode = 1;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int lim, input int dv, input bit rl);
    cfg_valid = 1'b1; cfg_limit = WIDTH'(lim); cfg_div = PRESC_W'(dv); cfg_reload = rl;
    next_cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; next_cycle(); start = 1'b0;
  endtask

  task automatic go_idle();
    clear = 1'b1; next_cycle(); clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit found;
    reset = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    n_cmp++; if (count_out !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", tick); end
    reset = 1'b0;
    next_cycle();
    // Reset in the middle of a run at count 5.
    configure(10, 0, 1'b0);
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (exp_count() == 5) found = 1'b1; else next_cycle();
    end
    n_cmp++; if (!found || count_out !== WIDTH'(5)) begin n_err++; $display("FAIL reset_run_reach5 got=%0d exp=5 found=%b", count_out, found); end
    reset = 1'b1; next_cycle(); reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (count_out !== '0) begin n_err++; $display("FAIL reset_run_count got=%0d exp=0", count_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_run_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_run_done got=%b exp=0", done); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_run_ready got=%b exp=1", cfg_ready); end
    next_cycle();
  endtask

  task automatic test_one_shot();
    int done_seen = 0;
    go_idle();
    configure(3, 1, 1'b0);
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      n_cmp++; if (count_out !== WIDTH'(exp_count())) begin n_err++; $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, count_out, exp_count()); end
      n_cmp++; if (tick !== exp_tick()) begin n_err++; $display("FAIL oneshot_tick k=%0d got=%b exp=%b", k, tick, exp_tick()); end
      n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL oneshot_done k=%0d got=%b exp=%b", k, done, m_done); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (count_out !== WIDTH'(3) || busy !== 1'b0) begin n_err++; $display("FAIL oneshot_end count=%0d busy=%b exp count=3 busy=0", count_out, busy); end
    n_cmp++; if (done_seen != 1) begin n_err++; $display("FAIL oneshot_pulses got=%0d exp=1", done_seen); end
    next_cycle();
  endtask

  task automatic test_reload();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] e;
    go_idle();
    configure(2, 0, 1'b1);
    pulse_start();
    exp_q = '{WIDTH'(1), WIDTH'(2), WIDTH'(0), WIDTH'(1), WIDTH'(2), WIDTH'(0)};
    while (exp_q.size() > 0) begin
      next_cycle();
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (count_out !== e) begin n_err++; $display("FAIL reload_count got=%0d exp=%0d", count_out, e); end
      n_cmp++; if (done !== (e == '0)) begin n_err++; $display("FAIL reload_done got=%b exp=%b", done, (e == '0)); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reload_busy got=%b exp=1", busy); end
    end
    next_cycle();
    go_idle();
  endtask

  task automatic test_pause();
    bit found = 1'b0;
    go_idle();
    configure(10, 0, 1'b0);
    pulse_start();
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (exp_count() == 3) found = 1'b1; else next_cycle();
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL pause_reach3 got=%0d exp=3", count_out); end
    stop = 1'b1; next_cycle(); stop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (count_out !== WIDTH'(4)) begin n_err++; $display("FAIL pause_hold k=%0d got=%0d exp=4", k, count_out); end
      n_cmp++; if (tick !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL pause_flags k=%0d tick=%b busy=%b exp tick=0 busy=1", k, tick, busy); end
      next_cycle();
    end
    pulse_start();
    @(negedge clk);
    n_cmp++; if (count_out !== WIDTH'(4) || tick !== 1'b1) begin n_err++; $display("FAIL resume_first count=%0d tick=%b exp count=4 tick=1", count_out, tick); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (count_out !== WIDTH'(5)) begin n_err++; $display("FAIL resume_next got=%0d exp=5", count_out); end
    next_cycle();
    go_idle();
  endtask

  task automatic test_clear_terminal();
    bit found = 1'b0;
    go_idle();
    configure(2, 1, 1'b0);
    pulse_start();
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (exp_tick() && exp_count() == 2) found = 1'b1; else next_cycle();
    end
    n_cmp++; if (!found || tick !== 1'b1 || count_out !== WIDTH'(2)) begin n_err++; $display("FAIL clrterm_reach tick=%b count=%0d exp tick=1 count=2", tick, count_out); end
    clear = 1'b1; next_cycle(); clear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL clrterm_done k=%0d got=%b exp=0", k, done); end
      n_cmp++; if (count_out !== '0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL clrterm_state count=%0d ready=%b busy=%b exp 0/1/0", count_out, cfg_ready, busy); end
      next_cycle();
    end
  endtask

  task automatic test_handshake();
    bit found = 1'b0;
    // Config offered mid-run is refused and does not alter the limit.
    go_idle();
    configure(4, 0, 1'b0);
    pulse_start();
    next_cycle();
    cfg_valid = 1'b1; cfg_limit = WIDTH'(1); cfg_div = '0; cfg_reload = 1'b1;
    @(negedge clk);
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL hs_ready_run got=%b exp=0", cfg_ready); end
    next_cycle();
    cfg_valid = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      n_cmp++; if (count_out !== WIDTH'(exp_count())) begin n_err++; $display("FAIL hs_run_count got=%0d exp=%0d", count_out, exp_count()); end
      if (m_mode == 0) found = 1'b1; else next_cycle();
    end
    n_cmp++; if (!found || count_out !== WIDTH'(4)) begin n_err++; $display("FAIL hs_limit_kept got=%0d exp=4", count_out); end
    next_cycle();
    // Handshake and start together, from a reset limit of 0.
    reset = 1'b1; next_cycle(); reset = 1'b0;
    cfg_valid = 1'b1; cfg_limit = WIDTH'(1); cfg_div = '0; cfg_reload = 1'b0; start = 1'b1;
    next_cycle();
    cfg_valid = 1'b0; start = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (count_out !== WIDTH'(1) || done !== 1'b0) begin n_err++; $display("FAIL hs_same_mid count=%0d done=%b exp 1/0", count_out, done); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || count_out !== WIDTH'(1) || busy !== 1'b0) begin n_err++; $display("FAIL hs_same_done done=%b count=%0d busy=%b exp 1/1/0", done, count_out, busy); end
    next_cycle();
    // Start with a zero limit is ignored, both latched and same-cycle.
    configure(0, 0, 1'b0);
    pulse_start();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_err++; $display("FAIL zero_limit busy=%b ready=%b exp 0/1", busy, cfg_ready); end
    configure(3, 0, 1'b0);
    cfg_valid = 1'b1; cfg_limit = '0; start = 1'b1;
    next_cycle();
    cfg_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_err++; $display("FAIL zero_limit_same busy=%b ready=%b exp 0/1", busy, cfg_ready); end
    next_cycle();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset      = ($urandom_range(0, 199) == 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_limit  = WIDTH'($urandom_range(0, 6));
      cfg_div    = PRESC_W'($urandom_range(0, 3));
      cfg_reload = 1'($urandom_range(0, 1));
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 9) == 0);
      clear      = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      n_cmp++; if (count_out !== WIDTH'(exp_count())) begin n_err++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count_out, exp_count()); end
      n_cmp++; if (tick !== exp_tick()) begin n_err++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_tick()); end
      n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", cyc, done, m_done); end
      n_cmp++; if (busy !== (m_mode != 0)) begin n_err++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, (m_mode != 0)); end
      n_cmp++; if (cfg_ready !== (m_mode == 0)) begin n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, (m_mode == 0)); end
      next_cycle();
    end
    reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_one_shot();
    test_reload();
    test_pause();
    test_clear_terminal();
    test_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
